// File: rtl/dpll_pkg.sv
// ---------------------------------------------------------------------------
// dpll_pkg
// Shared types and helpers for the DPLL frequency-locked-loop controller.
//   dpll_state_e  : loop state (IDLE, ACQUIRE, LOCKED, OPEN)
//   code_width()  : width of the binary trim code for a given trim width
//   therm_decode(): binary code -> thermometer word, bit i set when i < code
// ---------------------------------------------------------------------------
package dpll_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2,
        OPEN    = 2'd3
    } dpll_state_e;

    localparam int TRIM_W_DEF = 26;
    localparam int CODE_W_DEF = $clog2(TRIM_W_DEF + 1);
    // Widest trim word the decoder can produce.
    localparam int THERM_MAX  = 64;

    function automatic int code_width(input int trim_w);
        return $clog2(trim_w + 1);
    endfunction

    function automatic logic [THERM_MAX-1:0] therm_decode(input logic [7:0] code);
        logic [THERM_MAX-1:0] t;
        t = '0;
        for (int i = 0; i < THERM_MAX; i++) begin
            t[i] = (i < int'(code));
        end
        return t;
    endfunction

endpackage

// File: rtl/dpll_ref_edge_sync.sv
// ---------------------------------------------------------------------------
// dpll_ref_edge_sync
// Brings the asynchronous reference oscillator into the DCO clock domain and
// produces a one-cycle pulse per rising edge, 3 clocks after the osc rise.
//   clock    : DCO clock
//   reset    : synchronous active-high reset
//   osc      : asynchronous reference oscillator
//   ref_edge : registered rising-edge pulse
// ---------------------------------------------------------------------------
module dpll_ref_edge_sync (
    input  logic clock,
    input  logic reset,
    input  logic osc,
    output logic ref_edge
);

    logic sync1_r;
    logic sync2_r;
    logic prev_r;
    logic edge_r;

    // two-flop synchroniser, delayed copy, and registered rising-edge pulse
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            prev_r  <= 1'b0;
            edge_r  <= 1'b0;
        end else begin
            sync1_r <= osc;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
            edge_r  <= sync2_r & ~prev_r;
        end
    end

    assign ref_edge = edge_r;

endmodule

// File: rtl/dpll_fll_controller.sv
// ---------------------------------------------------------------------------
// dpll_fll_controller
// Frequency-locked-loop controller for the DPLL ring oscillator. Counts DCO
// cycles per reference period and steers a thermometer trim word so that the
// measured period matches div.
//   clock, reset : DCO clock, synchronous active-high reset
//   enable       : loop enable
//   osc          : asynchronous reference oscillator
//   div          : target DCO cycles per reference period
//   dco          : open-loop mode, trim follows ext_trim
//   ext_trim     : external trim word for open-loop mode
//   freeze       : hold the trim code while measuring continues
//   trim         : thermometer trim word to the oscillator
//   trim_code    : current binary trim code
//   locked       : lock indicator
//   meas         : last measured period
//   meas_valid   : one-cycle pulse when meas updates
// ---------------------------------------------------------------------------
module dpll_fll_controller
    import dpll_pkg::*;
#(
    parameter int TRIM_W    = TRIM_W_DEF,
    parameter int DIV_W     = 5,
    parameter int CNT_W     = 8,
    parameter int INIT_CODE = 13,
    parameter int TOL       = 1,
    parameter int COARSE_TH = 4,
    parameter int LOCK_N    = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          osc,
    input  logic [DIV_W-1:0]              div,
    input  logic                          dco,
    input  logic [TRIM_W-1:0]             ext_trim,
    input  logic                          freeze,
    output logic [TRIM_W-1:0]             trim,
    output logic [code_width(TRIM_W)-1:0] trim_code,
    output logic                          locked,
    output logic [CNT_W-1:0]              meas,
    output logic                          meas_valid
);

    localparam int                CODE_W    = code_width(TRIM_W);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W:0]    TOL_C     = (CNT_W+1)'(TOL);
    localparam logic [CNT_W:0]    HYST_C    = (CNT_W+1)'(TOL + 1);
    localparam logic [CNT_W:0]    COARSE_C  = (CNT_W+1)'(COARSE_TH);
    localparam logic [CODE_W:0]   MAX_CODE  = (CODE_W+1)'(TRIM_W);
    localparam logic [CODE_W-1:0] INIT_C    = CODE_W'(INIT_CODE);
    localparam logic [7:0]        LOCK_C    = 8'(LOCK_N);
    localparam logic [TRIM_W-1:0] INIT_TRIM = TRIM_W'(therm_decode(8'(INIT_CODE)));

    dpll_state_e        state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   meas_r;
    logic [CNT_W-1:0]   meas_next_s;
    logic               meas_valid_r;
    logic               first_r;
    logic               locked_r;
    logic [7:0]         inband_r;
    logic [CODE_W-1:0]  code_r;
    logic [CODE_W-1:0]  next_code_s;
    logic [TRIM_W-1:0]  trim_r;
    logic [TRIM_W-1:0]  therm_s;
    logic signed [CNT_W:0] err_s;
    logic [CNT_W:0]     abs_s;
    logic [CODE_W:0]    step_s;
    logic [CODE_W:0]    code_ext_s;
    logic [CODE_W:0]    sum_s;
    logic               loop_s;
    logic               in_band_s;
    logic               drop_s;
    logic               edge_s;

    dpll_ref_edge_sync u_ref_sync (
        .clock    (clock),
        .reset    (reset),
        .osc      (osc),
        .ref_edge (edge_s)
    );

    // signed error of the last measurement, its magnitude and band decisions
    always_comb begin
        err_s = $signed({1'b0, meas_r}) - $signed({{(CNT_W+1-DIV_W){1'b0}}, div});
        if (err_s[CNT_W]) begin
            abs_s = -err_s;
        end else begin
            abs_s = err_s;
        end
        in_band_s = (abs_s <= TOL_C);
        drop_s    = (abs_s > HYST_C);
        if (abs_s >= COARSE_C) begin
            step_s = (CODE_W+1)'(2);
        end else begin
            step_s = (CODE_W+1)'(1);
        end
        if (cnt_r == CNT_MAX) begin
            meas_next_s = CNT_MAX;
        end else begin
            meas_next_s = cnt_r + CNT_W'(1);
        end
    end

    // next trim code: step toward the target, saturating at 0 and TRIM_W
    always_comb begin
        code_ext_s  = {1'b0, code_r};
        sum_s       = code_ext_s + step_s;
        // the loop only acts in the cycle after a fresh measurement while active
        loop_s      = meas_valid_r & enable & ~dco &
                      ((state_r == ACQUIRE) | (state_r == LOCKED)) & (div != '0);
        next_code_s = code_r;
        if (loop_s && !freeze && !in_band_s) begin
            if (!err_s[CNT_W]) begin
                if (sum_s > MAX_CODE) begin
                    next_code_s = MAX_CODE[CODE_W-1:0];
                end else begin
                    next_code_s = sum_s[CODE_W-1:0];
                end
            end else begin
                if (code_ext_s < step_s) begin
                    next_code_s = '0;
                end else begin
                    next_code_s = code_r - step_s[CODE_W-1:0];
                end
            end
        end else begin
            next_code_s = code_r;
        end
        therm_s = TRIM_W'(therm_decode(8'(next_code_s)));
    end

    // loop state machine, period counter, lock tracking and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= IDLE;
            cnt_r        <= '0;
            meas_r       <= '0;
            meas_valid_r <= 1'b0;
            first_r      <= 1'b1;
            inband_r     <= '0;
            locked_r     <= 1'b0;
            code_r       <= INIT_C;
            trim_r       <= INIT_TRIM;
        end else begin
            meas_valid_r <= 1'b0;
            code_r       <= next_code_s;
            if (dco) begin
                trim_r <= ext_trim;
            end else begin
                trim_r <= therm_s;
            end

            if (dco) begin
                state_r  <= OPEN;
                cnt_r    <= '0;
                inband_r <= '0;
                locked_r <= 1'b0;
                first_r  <= 1'b1;
            end else begin
                case (state_r)
                    IDLE, OPEN: begin
                        cnt_r    <= '0;
                        inband_r <= '0;
                        locked_r <= 1'b0;
                        first_r  <= 1'b1;
                        // leaving open-loop always passes through IDLE first
                        if (enable && (state_r == IDLE)) begin
                            state_r <= ACQUIRE;
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                    ACQUIRE, LOCKED: begin
                        if (!enable) begin
                            state_r  <= IDLE;
                            cnt_r    <= '0;
                            inband_r <= '0;
                            locked_r <= 1'b0;
                        end else begin
                            if (edge_s) begin
                                cnt_r   <= '0;
                                first_r <= 1'b0;
                                // the first edge after IDLE only opens the window
                                if (!first_r) begin
                                    meas_r       <= meas_next_s;
                                    meas_valid_r <= 1'b1;
                                end
                            end else if (cnt_r != CNT_MAX) begin
                                cnt_r <= cnt_r + CNT_W'(1);
                            end

                            if (div == '0) begin
                                state_r  <= ACQUIRE;
                                inband_r <= '0;
                                locked_r <= 1'b0;
                            end else if (meas_valid_r) begin
                                if (state_r == ACQUIRE) begin
                                    if (in_band_s) begin
                                        if ((inband_r + 8'd1) >= LOCK_C) begin
                                            state_r  <= LOCKED;
                                            locked_r <= 1'b1;
                                            inband_r <= LOCK_C;
                                        end else begin
                                            inband_r <= inband_r + 8'd1;
                                        end
                                    end else begin
                                        inband_r <= '0;
                                    end
                                end else if (drop_s) begin
                                    // hysteresis: only errors beyond TOL+1 lose lock
                                    state_r  <= ACQUIRE;
                                    locked_r <= 1'b0;
                                    inband_r <= '0;
                                end
                            end
                        end
                    end
                    default: begin
                        state_r  <= IDLE;
                        cnt_r    <= '0;
                        inband_r <= '0;
                        locked_r <= 1'b0;
                        first_r  <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign trim       = trim_r;
    assign trim_code  = code_r;
    assign locked     = locked_r;
    assign meas       = meas_r;
    assign meas_valid = meas_valid_r;

endmodule

// File: tb/tb_dpll_fll_controller.sv
// ---------------------------------------------------------------------------
// tb_dpll_fll_controller
// Scoreboard bench: the stimulus side predicts each measurement and the loop
// response from the reference period it drives; a forked monitor pops the
// prediction whenever meas_valid pulses and checks meas, then trim_code, trim
// and locked one cycle later.
// ---------------------------------------------------------------------------
module tb_dpll_fll_controller;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        osc;
    logic [4:0]  div;
    logic        dco;
    logic [25:0] ext_trim;
    logic        freeze;
    logic [25:0] trim;
    logic [4:0]  trim_code;
    logic        locked;
    logic [7:0]  meas;
    logic        meas_valid;

    typedef struct {
        int meas;
        int code;
        int locked;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // reference model state
    int   m_code;
    int   m_inband;
    int   m_locked;
    int   m_last_per;
    bit   m_en;
    bit   m_armed;

    always #5 clock = ~clock;

    dpll_fll_controller dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .osc        (osc),
        .div        (div),
        .dco        (dco),
        .ext_trim   (ext_trim),
        .freeze     (freeze),
        .trim       (trim),
        .trim_code  (trim_code),
        .locked     (locked),
        .meas       (meas),
        .meas_valid (meas_valid)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] therm(input int code);
        logic [63:0] one;
        one = 64'd1;
        return (one << code) - one;
    endfunction

    // apply the loop rules to one measured period and queue the expectation
    task automatic model_measure(input int m);
        int   err;
        int   mag;
        int   step;
        exp_t e;
        err = m - int'(div);
        mag = (err < 0) ? -err : err;
        if (div == 5'd0) begin
            m_locked = 0;
            m_inband = 0;
        end else begin
            if (mag <= 1) begin
                m_inband++;
                if (m_inband >= 4) m_locked = 1;
            end else if (mag > 2) begin
                m_locked = 0;
                m_inband = 0;
            end else if (m_locked == 0) begin
                m_inband = 0;
            end
            if (!freeze && mag > 1) begin
                step = (mag >= 4) ? 2 : 1;
                if (err > 0) m_code = (m_code + step > 26) ? 26 : m_code + step;
                else         m_code = (m_code - step < 0) ? 0 : m_code - step;
            end
        end
        e.meas   = m;
        e.code   = m_code;
        e.locked = m_locked;
        q.push_back(e);
    endtask

    // reference rise: the period just finished is measured unless it is the first
    task automatic model_rise(input int per);
        if (m_en) begin
            if (m_armed) model_measure((m_last_per > 255) ? 255 : m_last_per);
            m_armed = 1'b1;
        end
        m_last_per = per;
    endtask

    task automatic send(input int per);
        model_rise(per);
        osc = 1'b1;
        repeat (per / 2) @(negedge clock);
        osc = 1'b0;
        repeat (per - per / 2) @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset    = 1'b0;
        m_code   = 13;
        m_inband = 0;
        m_locked = 0;
        m_armed  = 1'b0;
    endtask

    task automatic set_enable(input logic en);
        enable   = en;
        m_en     = en;
        m_armed  = 1'b0;
        m_inband = 0;
        m_locked = 0;
    endtask

    task automatic monitor();
        exp_t pend;
        bit   pending;
        pending = 1'b0;
        forever begin
            @(negedge clock);
            if (pending) begin
                check("trim_code_e2", trim_code, pend.code);
                check("trim_e2", trim, therm(pend.code));
                check("locked_e2", locked, pend.locked);
                pending = 1'b0;
            end
            if (meas_valid === 1'b1) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_meas_valid: got 1 expected 0");
                end else begin
                    pend = q.pop_front();
                    check("meas", meas, pend.meas);
                    pending = 1'b1;
                end
            end
        end
    endtask

    initial begin
        int per;
        fork
            monitor();
        join_none
        osc = 1'b0; enable = 1'b0; dco = 1'b0; freeze = 1'b0;
        div = 5'd20; ext_trim = '0; m_en = 1'b0; m_last_per = 0;
        @(negedge clock);
        do_reset();
        check("rst_trim", trim, 64'h1FFF);
        check("rst_trim_code", trim_code, 13);
        check("rst_locked", locked, 0);
        check("rst_meas", meas, 0);
        check("rst_meas_valid", meas_valid, 0);

        // nominal lock at div=20
        set_enable(1'b1);
        repeat (3) @(negedge clock);
        repeat (6) send(20);
        check("lock_after_4", locked, 1);
        check("lock_code", trim_code, 13);

        // err=+3 drops lock, relock, then err=+2 keeps lock
        send(23);
        repeat (5) send(20);
        check("relock", locked, 1);
        send(22);
        send(20);
        check("hyst_locked", locked, 1);
        check("hyst_code", trim_code, 15);

        // open-loop bypass
        dco = 1'b1; ext_trim = 26'h3FFFFFF; set_enable(1'b1); m_en = 1'b0;
        @(negedge clock);
        check("open_trim", trim, 64'h3FFFFFF);
        check("open_locked", locked, 0);
        check("open_code", trim_code, m_code);
        ext_trim = 26'h0A5A5A5;
        @(negedge clock);
        check("open_trim2", trim, 64'h0A5A5A5);
        repeat (2) send(20);
        dco = 1'b0; m_en = 1'b1; m_armed = 1'b0;
        @(negedge clock);
        check("open_exit_trim", trim, therm(m_code));
        repeat (2) @(negedge clock);
        repeat (3) send(20);

        // reset mid-operation
        osc = 1'b1;
        do_reset();
        osc = 1'b0;
        check("mid_rst_code", trim_code, 13);
        check("mid_rst_locked", locked, 0);
        check("mid_rst_trim", trim, 64'h1FFF);

        // coarse stepping up to saturation
        div = 5'd16;
        repeat (3) @(negedge clock);
        repeat (10) send(20);
        check("sat_high", trim_code, 26);
        check("sat_high_locked", locked, 0);

        // mirror: saturation at zero
        do_reset();
        div = 5'd31;
        repeat (3) @(negedge clock);
        repeat (12) send(8);
        check("sat_low", trim_code, 0);

        // freeze keeps the code while measuring
        do_reset();
        freeze = 1'b1; div = 5'd20;
        repeat (3) @(negedge clock);
        repeat (5) send(10);
        // enable dropped mid-period: partial period discarded
        model_rise(10);
        osc = 1'b1;
        repeat (6) @(negedge clock);
        set_enable(1'b0);
        repeat (4) @(negedge clock);
        osc = 1'b0;
        repeat (10) @(negedge clock);
        check("drop_code", trim_code, 13);
        check("drop_locked", locked, 0);
        repeat (2) send(10);
        set_enable(1'b1);
        repeat (3) @(negedge clock);
        repeat (2) send(10);
        check("freeze_code", trim_code, 13);

        // div=0: measurements reported, code fixed, never locked
        freeze = 1'b0; div = 5'd0;
        repeat (6) send(20);
        check("div0_locked", locked, 0);
        check("div0_code", trim_code, 13);

        // randomized periods, targets and freeze against the model
        do_reset();
        div = 5'd20;
        repeat (3) @(negedge clock);
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 7) == 0) div = 5'($urandom_range(14, 30));
            freeze = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 0) per = int'(div) + int'($urandom_range(0, 2)) - 1;
            else                           per = int'(div) + int'($urandom_range(0, 10)) - 5;
            send(per);
        end

        repeat (10) @(negedge clock);
        check("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
